// File: rtl/txd_arb_pkg.sv
// txd_arb_pkg: shared constants, state type and helpers for the TX pin arbiter.
//   Source indices : SRC_TAPE=0, SRC_MIDI=1, SRC_UART=2 (bit positions in src_in/src_en)
//   Grant encoding : GRANT_NONE=0, GRANT_TAPE=1, GRANT_MIDI=2, GRANT_UART=3
//   State type     : txd_arb_state_t {ST_IDLE, ST_OWNED}
package txd_arb_pkg;

   localparam int unsigned SRC_TAPE = 0;
   localparam int unsigned SRC_MIDI = 1;
   localparam int unsigned SRC_UART = 2;

   localparam logic [1:0] GRANT_NONE = 2'd0;
   localparam logic [1:0] GRANT_TAPE = 2'd1;
   localparam logic [1:0] GRANT_MIDI = 2'd2;
   localparam logic [1:0] GRANT_UART = 2'd3;

   typedef enum logic {ST_IDLE, ST_OWNED} txd_arb_state_t;

   // Fixed priority uart > midi > tape.
   function automatic logic [1:0] pick_grant(input logic [2:0] cand);
      logic [1:0] g;
      if (cand[SRC_UART])      g = GRANT_UART;
      else if (cand[SRC_MIDI]) g = GRANT_MIDI;
      else if (cand[SRC_TAPE]) g = GRANT_TAPE;
      else                     g = GRANT_NONE;
      return g;
   endfunction

   // One-hot source mask for a grant code; GRANT_NONE selects nothing.
   function automatic logic [2:0] grant_mask(input logic [1:0] g);
      logic [2:0] m;
      case (g)
         GRANT_TAPE: m = 3'b001;
         GRANT_MIDI: m = 3'b010;
         GRANT_UART: m = 3'b100;
         default:    m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/txd_idle_timer.sv
// txd_idle_timer: counts consecutive high cycles of the current owner's level.
//   clk_sys  in  : system clock (rising edge)
//   reset    in  : synchronous, active-high
//   i_level  in  : owner's serial level (idle high)
//   i_clear  in  : hold the counter at zero (no owner / forced release)
//   o_expire out : high in the cycle that completes IDLE_CYCLES consecutive high cycles
module txd_idle_timer
   import txd_arb_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 4266,
   parameter int unsigned IDLE_W      = 16
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic i_level,
   input  logic i_clear,
   output logic o_expire
);

   localparam logic [IDLE_W-1:0] LastCnt = IDLE_W'(IDLE_CYCLES - 1);

   logic [IDLE_W-1:0] r_cnt;
   logic              w_at_last;

   assign w_at_last = (r_cnt == LastCnt);
   assign o_expire  = i_level & w_at_last & ~i_clear;

   // A low level restarts the hold window; expiry also wraps back to zero.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear || !i_level || w_at_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/txd_arbiter.sv
// txd_arbiter: shares one serial TX pin between tape, MIDI and UART outputs.
// A source claims the line by going low (priority uart > midi > tape) and keeps it
// until it has been high for IDLE_CYCLES consecutive cycles or its enable drops.
//   clk_sys   in  1 : system clock
//   reset     in  1 : synchronous, active-high
//   src_in    in  3 : serial levels, idle high (0 tape, 1 midi, 2 uart)
//   src_en    in  3 : per-source enable
//   txd       out 1 : registered arbitrated output
//   grant     out 2 : owner (0 none, 1 tape, 2 midi, 3 uart)
//   busy      out 1 : grant != 0
//   stats_clr in  1 : zero the drop counters           (TXD_ARB_STATS_EN only)
//   drop_cnt* out 8 : saturating per-source drop counts (TXD_ARB_STATS_EN only)
// Optional feature macro: TXD_ARB_STATS_EN enables the drop counters.
module txd_arbiter
   import txd_arb_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 4266,
   parameter int unsigned IDLE_W      = 16
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [2:0] src_in,
   input  logic [2:0] src_en,
   output logic       txd,
   output logic [1:0] grant,
   output logic       busy
`ifdef TXD_ARB_STATS_EN
   ,
   input  logic       stats_clr,
   output logic [7:0] drop_cnt0,
   output logic [7:0] drop_cnt1,
   output logic [7:0] drop_cnt2
`endif
);

   txd_arb_state_t r_state, w_next_state;
   logic [1:0]     r_grant, w_next_grant;
   logic           r_txd, w_next_txd;

   logic [2:0] w_cand;
   logic [1:0] w_win;
   logic [2:0] w_own_mask;
   logic       w_own_level;
   logic       w_own_en;
   logic       w_timer_clear;
   logic       w_expire;

   assign w_cand      = src_en & ~src_in;
   assign w_win       = pick_grant(w_cand);
   assign w_own_mask  = grant_mask(r_grant);
   assign w_own_level = |(src_in & w_own_mask);
   assign w_own_en    = |(src_en & w_own_mask);

   txd_idle_timer #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .IDLE_W      (IDLE_W)
   ) u_idle_timer (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .i_level  (w_own_level),
      .i_clear  (w_timer_clear),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next_state  = r_state;
      w_next_grant  = r_grant;
      w_next_txd    = 1'b1;
      w_timer_clear = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (|w_cand) begin
               w_next_state = ST_OWNED;
               w_next_grant = w_win;
               w_next_txd   = |(src_in & grant_mask(w_win));
            end
         end
         ST_OWNED: begin
            w_timer_clear = ~w_own_en;
            if (!w_own_en) begin
               // Forced release drives the pin idle rather than the owner's level.
               w_next_state = ST_IDLE;
               w_next_grant = GRANT_NONE;
               w_next_txd   = 1'b1;
            end else if (w_expire) begin
               // No re-arbitration on the release cycle; next IDLE cycle decides.
               w_next_state = ST_IDLE;
               w_next_grant = GRANT_NONE;
               w_next_txd   = w_own_level;
            end else begin
               w_next_txd = w_own_level;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_grant = GRANT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= GRANT_NONE;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_next_state;
         r_grant <= w_next_grant;
         r_txd   <= w_next_txd;
      end
   end

   assign txd   = r_txd;
   assign grant = r_grant;
   assign busy  = (r_grant != GRANT_NONE);

`ifdef TXD_ARB_STATS_EN
   logic [2:0] r_src_q;
   logic [2:0] w_eff_mask;
   logic [2:0] w_drop;
   logic [7:0] r_drop_cnt [3];

   // Owner in effect this cycle, including a source winning right now.
   assign w_eff_mask = (r_state == ST_IDLE) ? grant_mask(w_win) : w_own_mask;
   assign w_drop     = r_src_q & ~src_in & src_en & ~w_eff_mask;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_src_q <= 3'b111;
      end else begin
         r_src_q <= src_in;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || stats_clr) begin
         for (int i = 0; i < 3; i++) r_drop_cnt[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_drop[i] && (r_drop_cnt[i] != 8'hFF)) begin
               r_drop_cnt[i] <= r_drop_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign drop_cnt0 = r_drop_cnt[SRC_TAPE];
   assign drop_cnt1 = r_drop_cnt[SRC_MIDI];
   assign drop_cnt2 = r_drop_cnt[SRC_UART];
`endif

endmodule

// File: tb/tb_txd_arbiter.sv
// tb_txd_arbiter: directed scenarios followed by randomized traffic, all checked
// against a cycle reference model that tracks owner and consecutive-high run length.
module tb_txd_arbiter;

   localparam int unsigned IDLE = 8;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [2:0] src_in;
   logic [2:0] src_en;
   logic       stats_clr;
   logic       txd;
   logic [1:0] grant;
   logic       busy;
`ifdef TXD_ARB_STATS_EN
   logic [7:0] drop_cnt0, drop_cnt1, drop_cnt2;
`endif

   always #5 clk_sys = ~clk_sys;

   txd_arbiter #(
      .IDLE_CYCLES (IDLE),
      .IDLE_W      (4)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .src_in    (src_in),
      .src_en    (src_en),
      .txd       (txd),
      .grant     (grant),
      .busy      (busy)
`ifdef TXD_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .drop_cnt0 (drop_cnt0),
      .drop_cnt1 (drop_cnt1),
      .drop_cnt2 (drop_cnt2)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   int         m_owner;   // 0 none, 1 tape, 2 midi, 3 uart
   int         m_run;     // consecutive high cycles of the owner
   logic       m_txd;
   logic [2:0] m_prev;
   int         m_drop [3];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [2:0] falls;
      int eff;
      if (reset) begin
         m_owner = 0; m_run = 0; m_txd = 1'b1; m_prev = 3'b111;
         for (int j = 0; j < 3; j++) m_drop[j] = 0;
         return;
      end
      falls = m_prev & ~src_in;
      eff   = m_owner;
      if (m_owner == 0) begin
         m_txd = 1'b1;
         for (int j = 0; j < 3; j++) if (src_en[j] && !src_in[j]) eff = j + 1;
         if (eff != 0) begin
            m_owner = eff; m_run = 0; m_txd = 1'b0;
         end
      end else if (!src_en[m_owner-1]) begin
         m_owner = 0; m_run = 0; m_txd = 1'b1;
      end else if (src_in[m_owner-1]) begin
         m_run++;
         m_txd = 1'b1;
         if (m_run == IDLE) begin
            m_owner = 0; m_run = 0;
         end
      end else begin
         m_run = 0; m_txd = 1'b0;
      end
      for (int j = 0; j < 3; j++) begin
         if (stats_clr) m_drop[j] = 0;
         else if (src_en[j] && falls[j] && (j + 1) != eff && m_drop[j] < 255) m_drop[j]++;
      end
      m_prev = src_in;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_sys);
      #1;
      cyc++;
      chk("grant", {6'd0, grant}, 8'(m_owner));
      chk("busy", {7'd0, busy}, {7'd0, (m_owner != 0)});
      chk("txd", {7'd0, txd}, {7'd0, m_txd});
`ifdef TXD_ARB_STATS_EN
      chk("drop_cnt0", drop_cnt0, 8'(m_drop[0]));
      chk("drop_cnt1", drop_cnt1, 8'(m_drop[1]));
      chk("drop_cnt2", drop_cnt2, 8'(m_drop[2]));
`endif
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1; src_in = 3'b111; src_en = 3'b111; stats_clr = 1'b0;
      m_owner = 0; m_run = 0; m_txd = 1'b1; m_prev = 3'b111;
      for (int j = 0; j < 3; j++) m_drop[j] = 0;
      #1;
      ticks(2);
      chk("rst_grant", {6'd0, grant}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_txd", {7'd0, txd}, 8'd1);
      reset = 1'b0;
      ticks(3);

      // Single midi frame: 3 low cycles then idle.
      src_in = 3'b101;
      tick();
      chk("midi_grant", {6'd0, grant}, 8'd2);
      chk("midi_txd0", {7'd0, txd}, 8'd0);
      ticks(2);
      src_in = 3'b111;
      tick();
      chk("midi_txd1", {7'd0, txd}, 8'd1);
      ticks(6);
      chk("midi_hold", {6'd0, grant}, 8'd2);
      tick();
      chk("midi_release", {6'd0, grant}, 8'd0);
      ticks(3);

      // Simultaneous start: tape and uart.
      src_in = 3'b010;
      tick();
      chk("sim_grant", {6'd0, grant}, 8'd3);
      chk("sim_txd", {7'd0, txd}, 8'd0);
`ifdef TXD_ARB_STATS_EN
      chk("sim_drop0", drop_cnt0, 8'd1);
`endif
      src_in = 3'b111; tick();
      src_in = 3'b011; tick();
      chk("sim_follow", {7'd0, txd}, 8'd0);
      src_in = 3'b111;
      ticks(IDLE + 2);

      // Interloper: midi falls twice while uart owns.
      src_in = 3'b011; tick();
      src_in = 3'b001; tick();
      chk("intl_txd", {7'd0, txd}, 8'd0);
      src_in = 3'b111; tick();
      chk("intl_txd_hi", {7'd0, txd}, 8'd1);
      src_in = 3'b101; tick();
      chk("intl_grant", {6'd0, grant}, 8'd3);
      chk("intl_txd2", {7'd0, txd}, 8'd1);
      src_in = 3'b111; ticks(IDLE + 2);
`ifdef TXD_ARB_STATS_EN
      chk("intl_drop1", drop_cnt1, 8'd2);
`endif
      src_in = 3'b101; tick();
      chk("intl_midi_win", {6'd0, grant}, 8'd2);
      src_in = 3'b111; ticks(IDLE + 2);

      // Enable withdrawal while tape owns with txd low.
      src_in = 3'b110; tick();
      chk("en_grant", {6'd0, grant}, 8'd1);
      src_en = 3'b110; tick();
      chk("en_drop_grant", {6'd0, grant}, 8'd0);
      chk("en_drop_txd", {7'd0, txd}, 8'd1);
      src_in = 3'b111; tick();
      src_en = 3'b111; ticks(2);

      // Saturation: uart holds the line low while midi falls 300 times.
      src_in = 3'b011; tick();
      for (int i = 0; i < 300; i++) begin
         src_in = 3'b001; tick();
         src_in = 3'b011; tick();
      end
`ifdef TXD_ARB_STATS_EN
      chk("sat_drop1", drop_cnt1, 8'd255);
`endif
      src_in = 3'b001; stats_clr = 1'b1; tick();
      stats_clr = 1'b0;
`ifdef TXD_ARB_STATS_EN
      chk("clr_drop1", drop_cnt1, 8'd0);
`endif

      // Reset mid-frame while uart owns with txd low.
      src_in = 3'b011; tick();
      chk("rmf_txd", {7'd0, txd}, 8'd0);
      reset = 1'b1; tick();
      chk("rmf_grant", {6'd0, grant}, 8'd0);
      chk("rmf_busy", {7'd0, busy}, 8'd0);
      chk("rmf_txd1", {7'd0, txd}, 8'd1);
      reset = 1'b0; src_in = 3'b111; ticks(2);

      // Randomized traffic with periodic quiet gaps so owners can release.
      for (int c = 0; c < 3000; c++) begin
         if ((c % 250) < 30) begin
            src_in = 3'b111;
         end else begin
            for (int j = 0; j < 3; j++) src_in[j] = ($urandom_range(0, 99) < 75);
         end
         if ($urandom_range(0, 99) < 2) src_en = 3'($urandom_range(0, 7));
         else if ($urandom_range(0, 99) < 10) src_en = 3'b111;
         reset     = ($urandom_range(0, 999) < 5);
         stats_clr = ($urandom_range(0, 99) < 2);
         tick();
      end
      reset = 1'b0; stats_clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
